// File: rtl/rx_sampler_counter.sv
// Oversampling front end of the UART receiver: bit-period/frame counters and a
// 3-sample mid-bit majority vote. Define RX_SYNC_EN to add a 2-flop input synchronizer.
module rx_sampler_counter #(
    parameter int PRESCALE = 8,  // legal values: 4, 6, 8
    parameter int BIT_W    = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             RX_IN,
    input  logic             cnt_en,
    input  logic             samp_en,
    output logic [2:0]       edge_cnt,
    output logic [BIT_W-1:0] bit_cnt,
    output logic             sampled_bit,
    output logic             samp_done
);

    localparam logic [2:0] EDGE_LAST = 3'(PRESCALE - 1);
    localparam logic [2:0] SAMP_0    = 3'(PRESCALE / 2 - 2);
    localparam logic [2:0] SAMP_1    = 3'(PRESCALE / 2 - 1);
    localparam logic [2:0] SAMP_2    = 3'(PRESCALE / 2);

    logic line;
    logic s0;
    logic s1;
    logic vote;

`ifdef RX_SYNC_EN
    logic [1:0] sync_q;

    // Reset to the idle level so no false start bit appears after reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], RX_IN};
        end
    end

    assign line = sync_q[1];
`else
    assign line = RX_IN;
`endif

    assign vote = (s0 & s1) | (s0 & line) | (s1 & line);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            edge_cnt    <= '0;
            bit_cnt     <= '0;
            sampled_bit <= 1'b1;
            samp_done   <= 1'b0;
            s0          <= 1'b1;
            s1          <= 1'b1;
        end else if (!cnt_en) begin
            // s0/s1 are left stale on purpose: both are rewritten before the next vote.
            edge_cnt  <= '0;
            bit_cnt   <= '0;
            samp_done <= 1'b0;
        end else begin
            if (edge_cnt == EDGE_LAST) begin
                edge_cnt <= '0;
                bit_cnt  <= bit_cnt + BIT_W'(1);
            end else begin
                edge_cnt <= edge_cnt + 3'd1;
            end

            samp_done <= 1'b0;
            if (samp_en) begin
                if (edge_cnt == SAMP_0) s0 <= line;
                if (edge_cnt == SAMP_1) s1 <= line;
                if (edge_cnt == SAMP_2) begin
                    sampled_bit <= vote;
                    samp_done   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/rx_sampler_counter.md
# rx_sampler_counter

Oversampling front end of the UART receiver. Counts clock edges within each bit period and bits within the frame, driving `edge_cnt`/`bit_cnt` to the RX controller. Takes a 3-sample majority vote of `RX_IN` around mid-bit and presents the result as `sampled_bit` with a one-cycle `samp_done` strobe, which the deserializer and the start/parity/stop checkers consume.

## Interface
Parameters:
- `PRESCALE`, default 8: clocks per bit. Legal values are 4, 6 and 8; other values are illegal.
- `BIT_W`, default 4: width of `bit_cnt`.

Ports:
- `CLK`  in  1  block clock, rising edge.
- `RST`  in  1  reset, asynchronous, active-high.
- `RX_IN`  in  1  serial line, idle high.
- `cnt_en`  in  1  counter enable from the RX controller.
- `samp_en`  in  1  sampling enable from the RX controller.
- `edge_cnt`  out  3  clock index within the current bit, 0..PRESCALE-1.
- `bit_cnt`  out  BIT_W  bit index within the frame. The start bit is 0, data bits are 1..8, then parity, then stop.
- `sampled_bit`  out  1  majority-voted value of the current bit.
- `samp_done`  out  1  one-cycle strobe: `sampled_bit` was updated on the previous edge.

## Operation
Sample points: S0 = PRESCALE/2-2, S1 = PRESCALE/2-1, S2 = PRESCALE/2. For the default PRESCALE of 8 these are 2, 3 and 4.

Counters:
- When `cnt_en`=1: `edge_cnt` increments each cycle.
- At `edge_cnt`=PRESCALE-1: `edge_cnt` wraps to 0 and `bit_cnt` increments.
- `bit_cnt` wraps from 2^BIT_W-1 to 0 with no saturation.
- When `cnt_en`=0: both counters are cleared to 0 on the next edge (synchronous clear). This overrides any increment.

Sampling (only when `samp_en`=1 and `cnt_en`=1):
- At the edge where `edge_cnt`=S0, capture the line into `s0`. At `edge_cnt`=S1, capture into `s1`.
- At the edge where `edge_cnt`=S2: `sampled_bit` <= majority(`s0`, `s1`, line), and `samp_done` <= 1.
- `samp_done` is otherwise 0, so it is high for exactly one cycle per bit, during `edge_cnt`=S2+1.
- With `samp_en`=0: `s0`, `s1` and `sampled_bit` hold, and `samp_done`=0.
- With `cnt_en`=0: no sampling occurs, `samp_done`=0, and `sampled_bit` holds.

Reset values: `edge_cnt`=0, `bit_cnt`=0, `sampled_bit`=1, `samp_done`=0, `s0`=`s1`=1.

Boundary conditions:
- `cnt_en` drops mid-bit: the partial `s0`/`s1` captures are discarded. The next bit restarts from `edge_cnt`=0, and `s0`/`s1` are overwritten before their next use.
- `cnt_en` re-asserted in the same cycle it was cleared: counting starts from 0 on the following edge. Stale counts are never produced.
- `RST` asserted mid-frame: all registers return to their reset values immediately (asynchronous). Counting resumes only after `RST` is low and `cnt_en`=1.
- Back-to-back frames (controller moves from Valid to START): the counters are cleared during the Valid cycle because `cnt_en`=0, so the new frame begins cleanly.

## Timing
- Counter latency: `edge_cnt` changes 1 cycle after the edge that samples `cnt_en`.
- Sampling latency: a line value at the S2 edge appears on `sampled_bit` 1 cycle later, coincident with `samp_done`.
- No combinational path from any input to any output; all outputs are registered.

## Configuration
- `RX_SYNC_EN` defined:
  - `RX_IN` passes through a 2-flop synchronizer, reset value 1, before sampling. "Line" in Operation means the synchronizer output.
  - Sampled values lag the pin by 2 cycles.
  - The controller's start detection must account for this lag; integration is responsible.
- `RX_SYNC_EN` undefined:
  - `RX_IN` is sampled directly. The source must be synchronous to `CLK`.

## Test plan
- Reset: hold `RST`=1 with random inputs -> `edge_cnt`=0, `bit_cnt`=0, `sampled_bit`=1, `samp_done`=0. Deassert `RST` with `cnt_en`=0 -> all outputs unchanged.
- Count/wrap: `cnt_en`=1 for 88 cycles, PRESCALE=8 -> `edge_cnt` cycles 0..7. `bit_cnt` reaches 11 on cycle 88. Exactly 11 `samp_done` pulses, each while `edge_cnt`=5.
- Majority vote: within one bit, drive `RX_IN`=0,1,0 at edges 2,3,4 -> `sampled_bit`=0. Drive 1,0,1 -> 1. Drive 0,0,1 -> 0.
- Frame 0xA5 LSB-first with start and stop bits, `samp_en`=`cnt_en`=1 -> `sampled_bit` sequence 0,1,0,1,0,0,1,0,1,1, each with one `samp_done`.
- Abort: drop `cnt_en` at `edge_cnt`=3 of bit 4 -> both counters are 0 on the next cycle, no `samp_done`, and `sampled_bit` holds its last value. Assert `RST` at `edge_cnt`=6 -> immediate reset values.
- With `RX_SYNC_EN`, repeat the 0xA5 frame with `RX_IN` advanced 2 cycles -> identical `sampled_bit` and `samp_done` sequence.
